axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
- AXI4 slave that terminates a remapped master-side AXI port (CPU memory or GPU metadata) with on-chip memory.
- Used for FPGA bring-up without PS DDR, and as a bench stand-in for the DDR port.
- Supports single transactions with FIXED, INCR and WRAP bursts, full-width beats, and byte strobes.
- Handles one transaction at a time; read and write requests are arbitrated fairly.

Parameters:
- ADDR_W, 32: AXI address width.
- DATA_W, 64: AXI data width, in bits (power of two, ≥32).
- ID_W, 8: AXI ID width.
- MEM_BYTES, 65536: memory size in bytes (power of two).
- BASE, 32'h0000_0000: address of memory byte 0.

Ports:
- uncoreclk in 1: clock.
- uncorerst in 1: synchronous active-high reset.
- s_axi_awid in ID_W: write ID.
- s_axi_awaddr in ADDR_W: write start address.
- s_axi_awlen in 8: write beats minus 1.
- s_axi_awburst in 2: write burst type.
- s_axi_awvalid in 1: AW valid.
- s_axi_awready out 1: AW ready.
- s_axi_wdata in DATA_W: write data.
- s_axi_wstrb in DATA_W/8: byte strobes.
- s_axi_wlast in 1: last write beat.
- s_axi_wvalid in 1: W valid.
- s_axi_wready out 1: W ready.
- s_axi_bid out ID_W: response ID.
- s_axi_bresp out 2: write response.
- s_axi_bvalid out 1: B valid.
- s_axi_bready in 1: B ready.
- s_axi_arid in ID_W: read ID.
- s_axi_araddr in ADDR_W: read start address.
- s_axi_arlen in 8: read beats minus 1.
- s_axi_arburst in 2: read burst type.
- s_axi_arvalid in 1: AR valid.
- s_axi_arready out 1: AR ready.
- s_axi_rid out ID_W: read ID.
- s_axi_rdata out DATA_W: read data.
- s_axi_rresp out 2: read response.
- s_axi_rlast out 1: last read beat.
- s_axi_rvalid out 1: R valid.
- s_axi_rready in 1: R ready.

Behaviour:
- Clocking and reset:
  - Single clock, uncoreclk.
  - Reset is synchronous and active-high (uncorerst).
  - On reset, all outputs are 0 and the FSM is IDLE.
  - The next grant after reset goes to write.
  - Memory contents are not reset.
  - Reset mid-transaction aborts it; no B or R response is issued for it.
- Beat size:
  - AxSIZE is not ported; every beat is DATA_W wide.
  - Addresses are aligned down to DATA_W/8.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE:
  - awready and arready are driven combinationally: ready = valid && granted.
  - Grant when both are valid: the channel not granted last time.
  - Grant when only one is valid: that channel.
  - On the handshake, latch ID, address, len and burst, and clear the error accumulator.
  - Go to WR_DATA (write grant) or RD_DATA (read grant).
- WR_DATA:
  - wready = 1.
  - Each W handshake writes the strobed bytes at the current address, then advances the address.
  - After beat len+1, go to WR_RESP. The beat count ends the burst; wlast does not.
  - wlast asserted on a beat other than the final one, or deasserted on the final one, sets SLVERR.
- WR_RESP:
  - bvalid = 1 with bid = latched ID and bresp = accumulated error.
  - Hold until bready, then go to IDLE.
- RD_DATA:
  - Memory read is synchronous, 1-cycle.
  - The output register loads when !rvalid || rready.
  - AR handshake at cycle T gives the first rvalid at T+2.
  - Beats are back-to-back while rready is held, so throughput is 1 beat/cycle.
  - rlast is asserted on beat len+1.
  - After that beat's handshake, go to IDLE with rvalid = 0.
  - rvalid, rdata, rresp and rlast stay stable while rvalid && !rready.
- Addressing and error rules:
  - The memory word is indexed by (addr-BASE)[log2(MEM_BYTES)-1 : log2(DATA_W/8)].
  - Addresses outside [BASE, BASE+MEM_BYTES): the beat is not written, reads return rdata 0, and resp is DECERR.
  - Write DECERR is sticky for the rest of the burst.
  - Read DECERR applies per beat.
- Burst rules:
  - FIXED: the address is held for all beats.
  - INCR: address += DATA_W/8 per beat. 4 KB crossings are not checked.
  - WRAP: len must be 1, 3, 7 or 15. Wrap boundary = (len+1)·DATA_W/8; the address wraps to the aligned boundary base.
  - WRAP with any other len, or burst 2'b11: SLVERR on B / every R beat, and addressing behaves as INCR.
  - DECERR takes precedence over SLVERR.
- No interleaving: a second request waits in IDLE until the current response completes.

Decomposition:
- Shared package axi_pkg holds:
  - burst encodings (FIXED=0, INCR=1, WRAP=2);
  - resp encodings (OKAY=0, SLVERR=2, DECERR=3);
  - the responder FSM state enum.
- Sub-module axi_burst_addr: combinational next-address function (inputs: addr, len, burst; outputs: next addr, wrap_err). It is instantiated once for the write path and once for the read path.

Test Plan:
- Reset; INCR write at BASE, len=3, wstrb all-ones, data 1..4; then INCR read, same address → B OKAY with matching bid. R beats 1..4 at 1/cycle, first rvalid 2 cycles after the AR handshake, rlast on beat 4.
- WRAP read at BASE+0x18, len=3, DATA_W=64 → addresses 0x18, 0x00, 0x08, 0x10 (relative to BASE), all OKAY.
- Write with wstrb=8'h0F over a word holding 0xFFFF_FFFF_FFFF_FFFF, data 0 → read-back 0xFFFF_FFFF_0000_0000.
- awvalid and arvalid asserted together, twice in a row → first grant write, then read. Repeat after idle → grants alternate.
- Read at BASE+MEM_BYTES-8, INCR, len=1 → beat 0 OKAY with data; beat 1 rdata 0, DECERR.
- Write len=3 with wlast on beat 2; random rready stalls on a read → bresp SLVERR after 4 beats. R outputs stay stable during stalls. uncorerst mid-burst → all valids 0 next cycle.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings and responder state type for the on-chip memory responder.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_WR_RESP = 2'd2,
        ST_RD_DATA = 2'd3
    } state_t;

    // Numeric order OKAY < SLVERR < DECERR matches error precedence.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts of full-width beats.
module axi_burst_addr #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              wrap_err
);
    import axi_pkg::*;

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned LB    = $clog2(BYTES);

    logic              wrap_len_ok;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] mask;

    always_comb begin
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        wrap_err    = (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
        step        = addr + ADDR_W'(BYTES);
        // len+1 is a power of two here, so the wrap window mask is len shifted into the beat field.
        mask        = (ADDR_W'(len[3:0]) << LB) | ADDR_W'(BYTES - 1);
        if (burst == BURST_FIXED)
            next_addr = addr;
        else if ((burst == BURST_WRAP) && wrap_len_ok)
            next_addr = (addr & ~mask) | (step & mask);
        else
            next_addr = step;
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by on-chip memory; one transaction at a time, fair read/write arbitration.
module axi_mem_responder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       ID_W      = 8,
    parameter int unsigned       MEM_BYTES = 65536,
    parameter logic [ADDR_W-1:0] BASE      = '0
) (
    input  logic                  uncoreclk,
    input  logic                  uncorerst,
    input  logic [ID_W-1:0]       s_axi_awid,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_W-1:0]       s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_W-1:0]       s_axi_arid,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_W-1:0]       s_axi_rid,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    import axi_pkg::*;

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned LB    = $clog2(BYTES);
    localparam int unsigned WORDS = MEM_BYTES / BYTES;
    localparam int unsigned IDX_W = $clog2(WORDS);

    state_t              state;
    logic                wr_prio;
    logic [ID_W-1:0]     id_q;
    logic [7:0]          len_q;
    logic [1:0]          burst_q;
    logic [ADDR_W-1:0]   wr_addr, rd_addr;
    logic [7:0]          beat_cnt;
    logic                rd_issue_done;
    logic [1:0]          err_q;
    logic                rvalid_q, rlast_q;
    logic [1:0]          rresp_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [DATA_W-1:0]   mem [WORDS];

    logic [ADDR_W-1:0]   wr_next, rd_next, wr_off, rd_off;
    logic                wr_wrap_err, rd_wrap_err, wr_hit, rd_hit;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic                grant_wr, aw_hs, ar_hs, w_fire, rd_issue, wr_last;
    logic [1:0]          wr_beat_resp, rd_beat_resp;

    axi_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_addr (
        .addr(wr_addr), .len(len_q), .burst(burst_q),
        .next_addr(wr_next), .wrap_err(wr_wrap_err)
    );

    axi_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_addr (
        .addr(rd_addr), .len(len_q), .burst(burst_q),
        .next_addr(rd_next), .wrap_err(rd_wrap_err)
    );

    always_comb begin
        wr_off   = wr_addr - BASE;
        rd_off   = rd_addr - BASE;
        // Offsets below BASE wrap to large values and fail the same compare.
        wr_hit   = {1'b0, wr_off} < (ADDR_W+1)'(MEM_BYTES);
        rd_hit   = {1'b0, rd_off} < (ADDR_W+1)'(MEM_BYTES);
        wr_idx   = wr_off[LB +: IDX_W];
        rd_idx   = rd_off[LB +: IDX_W];

        grant_wr = s_axi_awvalid && (!s_axi_arvalid || wr_prio);
        aw_hs    = !uncorerst && (state == ST_IDLE) && grant_wr;
        ar_hs    = !uncorerst && (state == ST_IDLE) && s_axi_arvalid && !grant_wr;
        w_fire   = !uncorerst && (state == ST_WR_DATA) && s_axi_wvalid;
        rd_issue = (state == ST_RD_DATA) && !rd_issue_done && (!rvalid_q || s_axi_rready);
        wr_last  = (beat_cnt == len_q);

        wr_beat_resp = resp_merge(wr_hit ? RESP_OKAY : RESP_DECERR,
                                  (wr_wrap_err || (s_axi_wlast != wr_last)) ? RESP_SLVERR : RESP_OKAY);
        rd_beat_resp = resp_merge(rd_hit ? RESP_OKAY : RESP_DECERR,
                                  rd_wrap_err ? RESP_SLVERR : RESP_OKAY);
    end

    assign s_axi_awready = aw_hs;
    assign s_axi_arready = ar_hs;
    assign s_axi_wready  = !uncorerst && (state == ST_WR_DATA);
    assign s_axi_bvalid  = !uncorerst && (state == ST_WR_RESP);
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = err_q;
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rvalid  = rvalid_q;

    always_ff @(posedge uncoreclk) begin
        if (w_fire && wr_hit) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (s_axi_wstrb[b])
                    mem[wr_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // The read data register is also the memory's synchronous output register.
    always_ff @(posedge uncoreclk) begin
        if (uncorerst) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (rd_issue) begin
            rvalid_q <= 1'b1;
            rlast_q  <= (beat_cnt == len_q);
            rresp_q  <= rd_beat_resp;
            rdata_q  <= rd_hit ? mem[rd_idx] : '0;
        end else if (s_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge uncoreclk) begin
        if (uncorerst) begin
            state         <= ST_IDLE;
            wr_prio       <= 1'b1;
            id_q          <= '0;
            len_q         <= '0;
            burst_q       <= BURST_FIXED;
            wr_addr       <= '0;
            rd_addr       <= '0;
            beat_cnt      <= '0;
            rd_issue_done <= 1'b0;
            err_q         <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        id_q     <= s_axi_awid;
                        wr_addr  <= s_axi_awaddr & ~ADDR_W'(BYTES - 1);
                        len_q    <= s_axi_awlen;
                        burst_q  <= s_axi_awburst;
                        beat_cnt <= '0;
                        err_q    <= RESP_OKAY;
                        wr_prio  <= 1'b0;
                        state    <= ST_WR_DATA;
                    end else if (ar_hs) begin
                        id_q          <= s_axi_arid;
                        rd_addr       <= s_axi_araddr & ~ADDR_W'(BYTES - 1);
                        len_q         <= s_axi_arlen;
                        burst_q       <= s_axi_arburst;
                        beat_cnt      <= '0;
                        rd_issue_done <= 1'b0;
                        err_q         <= RESP_OKAY;
                        wr_prio       <= 1'b1;
                        state         <= ST_RD_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (s_axi_wvalid) begin
                        wr_addr  <= wr_next;
                        beat_cnt <= beat_cnt + 8'd1;
                        err_q    <= resp_merge(err_q, wr_beat_resp);
                        if (wr_last)
                            state <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (s_axi_bready)
                        state <= ST_IDLE;
                end
                ST_RD_DATA: begin
                    if (rd_issue) begin
                        rd_addr  <= rd_next;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_cnt == len_q)
                            rd_issue_done <= 1'b1;
                    end
                    if (rvalid_q && s_axi_rready && rlast_q)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: byte-level memory model plus a per-cycle response checker.
`timescale 1ns/1ps
module tb_axi_mem_responder;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned ID_W      = 8;
    localparam int unsigned MEM_BYTES = 4096;
    localparam logic [31:0] BASE      = 32'h4000_0000;

    logic clk = 1'b0;
    logic uncorerst = 1'b1;
    logic [ID_W-1:0] awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic        awvalid = 0, arvalid = 0, wvalid = 0, wlast = 0, bready = 0, rready = 0;
    logic        awready, arready, wready, bvalid, rvalid, rlast;
    logic [63:0] wdata = '0, rdata;

    always #5 clk = ~clk;

    axi_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                        .MEM_BYTES(MEM_BYTES), .BASE(BASE)) dut (
        .uncoreclk(clk), .uncorerst(uncorerst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    int unsigned pass_cnt = 0, tot_cnt = 0;
    longint unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [ID_W-1:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rbeat_t;
    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } bbeat_t;
    logic [7:0] mdl [MEM_BYTES];
    rbeat_t exp_r[$], got_r[$];
    bbeat_t exp_b[$], got_b[$];
    byte    grant_log[$];

    function automatic bit len_ok(input logic [7:0] len);
        return len == 1 || len == 3 || len == 7 || len == 15;
    endfunction

    function automatic bit burst_bad(input logic [1:0] b, input logic [7:0] len);
        return b == 2'd3 || (b == 2'd2 && !len_ok(len));
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [1:0] b, input int i);
        longint unsigned al, size, lo;
        al = 64'(a) - 64'(a % 8);
        if (b == 2'd0) return 32'(al);
        if (b == 2'd2 && len_ok(len)) begin
            size = (64'(len) + 1) * 8;
            lo   = al - (al % size);
            return 32'(lo + (al - lo + 64'(i) * 8) % size);
        end
        return 32'(al + 64'(i) * 8);
    endfunction

    function automatic bit in_mem(input logic [31:0] a);
        return 64'(a) >= 64'(BASE) && 64'(a) < 64'(BASE) + 64'(MEM_BYTES);
    endfunction

    function automatic logic [63:0] mdl_word(input logic [31:0] a);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[k*8 +: 8] = mdl[int'(a - BASE) + k];
        return w;
    endfunction

    function automatic void model_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                                       input logic [7:0] len, input logic [1:0] b);
        rbeat_t r;
        logic [31:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, b, i);
            r.id   = id;
            r.last = (i == int'(len));
            if (in_mem(a)) begin r.data = mdl_word(a); r.resp = burst_bad(b, len) ? 2'd2 : 2'd0; end
            else begin r.data = '0; r.resp = 2'd3; end
            exp_r.push_back(r);
        end
    endfunction

    function automatic void model_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                                        input logic [7:0] len, input logic [1:0] b,
                                        input logic [63:0] d0, input logic [63:0] dinc,
                                        input logic [7:0] strb, input int wlast_at);
        bbeat_t r;
        bit dec = 0, slv;
        logic [31:0] a;
        logic [63:0] d;
        slv = burst_bad(b, len);
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, b, i);
            d = d0 + 64'(i) * dinc;
            if (in_mem(a)) begin
                for (int k = 0; k < 8; k++) if (strb[k]) mdl[int'(a - BASE) + k] = d[k*8 +: 8];
            end else dec = 1;
            if ((i == wlast_at) != (i == int'(len))) slv = 1;
        end
        r.id = id;
        r.resp = dec ? 2'd3 : (slv ? 2'd2 : 2'd0);
        exp_b.push_back(r);
    endfunction

    // ---------------- per-cycle compare process ----------------
    logic        r_stall = 1'b0;
    logic [63:0] r_prev_data;
    logic [1:0]  r_prev_resp;
    logic        r_prev_last;
    always @(negedge clk) begin
        rbeat_t e;
        bbeat_t eb;
        if (uncorerst) r_stall = 1'b0;
        else begin
            if (r_stall)
                chk("r_stable", 64'(rvalid && rdata === r_prev_data && rresp === r_prev_resp
                                    && rlast === r_prev_last), 64'd1);
            if (rvalid && rready) begin
                got_r.push_back('{id: rid, data: rdata, resp: rresp, last: rlast});
                if (exp_r.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL r_unexpected: got beat data %h, required no beat", rdata);
                end else begin
                    e = exp_r.pop_front();
                    chk("r_id", rid, e.id);
                    chk("r_data", rdata, e.data);
                    chk("r_resp", rresp, e.resp);
                    chk("r_last", rlast, e.last);
                end
            end
            if (bvalid && bready) begin
                got_b.push_back('{id: bid, resp: bresp});
                if (exp_b.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL b_unexpected: got bresp %0d, required no response", bresp);
                end else begin
                    eb = exp_b.pop_front();
                    chk("b_id", bid, eb.id);
                    chk("b_resp", bresp, eb.resp);
                end
            end
            if (awready) grant_log.push_back("W");
            if (arready) grant_log.push_back("R");
            r_stall     = rvalid && !rready;
            r_prev_data = rdata;
            r_prev_resp = rresp;
            r_prev_last = rlast;
        end
    end

    // ---------------- drivers ----------------
    function automatic logic sig(input int w);
        case (w)
            0: return awready;
            1: return wready;
            2: return bvalid;
            default: return arready;
        endcase
    endfunction

    task automatic wait_hi(input int w, input string name);
        int n = 0;
        @(negedge clk);
        while (!sig(w) && n < 200) begin @(negedge clk); n++; end
        if (!sig(w)) begin
            tot_cnt++;
            $display("FAIL %s: timed out with signal 0, required 1", name);
        end
    endtask

    task automatic wr_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] b, input logic [63:0] d0, input logic [63:0] dinc,
                            input logic [7:0] strb, input int wlast_at);
        model_write(id, addr, len, b, d0, dinc, strb, wlast_at);
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awburst = b; awvalid = 1;
        wait_hi(0, "aw_handshake");
        @(posedge clk); #1;
        awvalid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = d0 + 64'(i) * dinc; wstrb = strb; wlast = (i == wlast_at); wvalid = 1;
            wait_hi(1, "w_handshake");
            @(posedge clk); #1;
        end
        wvalid = 0; wlast = 0; bready = 1;
        wait_hi(2, "b_handshake");
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic rd_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] b, input bit rand_ready, input bit chk_timing);
        int n = 0, beats = 0;
        longint unsigned hs_cyc, first_cyc = 0, last_cyc = 0;
        model_read(id, addr, len, b);
        got_r.delete();
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arburst = b; arvalid = 1;
        wait_hi(3, "ar_handshake");
        hs_cyc = cyc;
        @(posedge clk); #1;
        arvalid = 0;
        while (beats <= int'(len) && n < 500) begin
            rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (rvalid && rready) begin
                if (beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats++;
            end
            @(posedge clk); #1;
            n++;
        end
        rready = 0;
        if (beats <= int'(len)) begin
            tot_cnt++;
            $display("FAIL r_beats: got %0d beats, required %0d", beats, int'(len) + 1);
        end
        if (chk_timing) begin
            chk("r_first_latency", first_cyc - hs_cyc, 64'd2);
            chk("r_throughput", last_cyc - first_cyc, 64'(len));
        end
    endtask

    task automatic chk_rx(input string name, input int i, input logic [63:0] d, input logic [1:0] r);
        if (i >= got_r.size()) begin
            tot_cnt++;
            $display("FAIL %s: got %0d beats, required beat %0d", name, got_r.size(), i);
        end else begin
            chk({name, "_data"}, got_r[i].data, d);
            chk({name, "_resp"}, got_r[i].resp, r);
        end
    endtask

    task automatic chk_b(input string name, input logic [ID_W-1:0] id, input logic [1:0] r);
        if (got_b.size() == 0) begin
            tot_cnt++;
            $display("FAIL %s: got no B response, required one", name);
        end else begin
            chk({name, "_id"}, got_b[0].id, id);
            chk({name, "_resp"}, got_b[0].resp, r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_g = "WRWR";
        logic [63:0] wrap_exp [4];
        wrap_exp = '{64'd4, 64'd1, 64'd2, 64'd3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 64'({awready, arready, wready, bvalid, bid, bresp, rvalid, rid, rresp, rlast}), 64'd0);
        chk("reset_rdata", rdata, 64'd0);
        @(posedge clk); #1;
        uncorerst = 0;

        // INCR write 1..4 then INCR read-back with latency/throughput timing
        got_b.delete();
        wr_burst(8'h5A, BASE, 8'd3, 2'd1, 64'd1, 64'd1, 8'hFF, 3);
        chk_b("incr_wr_b", 8'h5A, 2'd0);
        rd_burst(8'hA5, BASE, 8'd3, 2'd1, 0, 1);
        for (int i = 0; i < 4; i++) chk_rx("incr_rd", i, 64'(i + 1), 2'd0);

        // WRAP from +0x18: words 0x18,0x00,0x08,0x10
        rd_burst(8'h11, BASE + 32'h18, 8'd3, 2'd2, 0, 0);
        for (int i = 0; i < 4; i++) chk_rx("wrap_rd", i, wrap_exp[i], 2'd0);

        // byte strobes over an all-ones word
        wr_burst(8'h21, BASE + 32'h40, 8'd0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'hFF, 0);
        wr_burst(8'h22, BASE + 32'h40, 8'd0, 2'd1, 64'd0, 64'd0, 8'h0F, 0);
        rd_burst(8'h23, BASE + 32'h40, 8'd0, 2'd1, 0, 0);
        chk_rx("strobe_rd", 0, 64'hFFFF_FFFF_0000_0000, 2'd0);

        // FIXED write keeps last beat; out-of-range write DECERR
        wr_burst(8'h31, BASE + 32'h80, 8'd1, 2'd0, 64'hA, 64'd1, 8'hFF, 1);
        rd_burst(8'h32, BASE + 32'h80, 8'd0, 2'd1, 0, 0);
        chk_rx("fixed_rd", 0, 64'hB, 2'd0);
        got_b.delete();
        wr_burst(8'h33, BASE - 32'h8, 8'd0, 2'd1, 64'h5, 64'd0, 8'hFF, 0);
        chk_b("below_base_wr", 8'h33, 2'd3);

        // top-of-memory INCR read crosses into DECERR
        wr_burst(8'h41, BASE + MEM_BYTES - 8, 8'd0, 2'd1, 64'hDEAD_BEEF_0123_4567, 64'd0, 8'hFF, 0);
        rd_burst(8'h42, BASE + MEM_BYTES - 8, 8'd1, 2'd1, 0, 0);
        chk_rx("edge_rd0", 0, 64'hDEAD_BEEF_0123_4567, 2'd0);
        chk_rx("edge_rd1", 1, 64'd0, 2'd3);

        // illegal WRAP length behaves as INCR with SLVERR
        rd_burst(8'h51, BASE + 32'h8, 8'd2, 2'd2, 0, 0);
        chk_rx("badwrap_rd", 0, 64'd2, 2'd2);

        // early wlast -> SLVERR, then stalled random-rready read over 8 words
        got_b.delete();
        wr_burst(8'h61, BASE + 32'h20, 8'd3, 2'd1, 64'd5, 64'd1, 8'hFF, 1);
        chk_b("wlast_err_wr", 8'h61, 2'd2);
        rd_burst(8'h62, BASE, 8'd7, 2'd1, 1, 0);
        for (int i = 0; i < 8; i++) chk_rx("stall_rd", i, 64'(i + 1), 2'd0);

        // simultaneous requests: fresh reset, two rounds
        @(posedge clk); #1; uncorerst = 1;
        @(posedge clk); #1; uncorerst = 0;
        grant_log.delete();
        fork
            wr_burst(8'h71, BASE + 32'h100, 8'd0, 2'd1, 64'h71, 64'd0, 8'hFF, 0);
            rd_burst(8'h72, BASE + 32'h8, 8'd0, 2'd1, 0, 0);
        join
        fork
            wr_burst(8'h73, BASE + 32'h108, 8'd0, 2'd1, 64'h73, 64'd0, 8'hFF, 0);
            rd_burst(8'h74, BASE + 32'h10, 8'd0, 2'd1, 0, 0);
        join
        for (int i = 0; i < 4; i++) begin
            if (i >= grant_log.size()) begin
                tot_cnt++;
                $display("FAIL grant_order: got %0d grants, required grant %0d", grant_log.size(), i);
            end else chk("grant_order", 64'(grant_log[i]), 64'(exp_g[i]));
        end

        // reset during a stalled read: no response survives
        @(posedge clk); #1;
        arid = 8'h81; araddr = BASE; arlen = 8'd7; arburst = 2'd1; arvalid = 1; rready = 0;
        wait_hi(3, "ar_handshake");
        @(posedge clk); #1;
        arvalid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_rvalid", 64'(rvalid), 64'd1);
        uncorerst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_reset_valids", 64'({rvalid, bvalid, rlast}), 64'd0);
        @(posedge clk); #1;
        uncorerst = 0;
        rready = 1; bready = 1;
        repeat (10) @(posedge clk);
        #1;
        rready = 0; bready = 0;

        chk("r_pending", 64'(exp_r.size()), 64'd0);
        chk("b_pending", 64'(exp_b.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
